mem_access_unit: RTL and testbench

//  Initiator side of the data-memory interface: takes one load/store per transaction from the

---
 rtl/mem_access_unit_if.sv | 80 ++++++++
 rtl/mem_access_unit.sv | 282 ++++++++++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_if.sv
// -----------------------------------------------------------------------------
// mem_access_unit_pkg / mem_access_unit_if
//
// Shared encodings and the bundled signal interface for mem_access_unit.
//
// The package holds the access-width encoding (the memWidth1/2/4 values used
// throughout the pipeline) and the response exception codes.
//
// The interface groups the pipeline request/response handshake and the
// word-wide data-memory req/ack bus. Signal names match the original flat
// port list of mem_access_unit.
//   master : the view used by mem_access_unit (the bus initiator)
//   slave  : the view used by the surroundings (pipeline MEM stage + memory)
//
//   req_valid/req_ready      pipeline request handshake (ready only in IDLE)
//   req_write                1=store, 0=load
//   req_width                access width (memWidth_t encoding)
//   req_sign_ext             loads: sign-extend sub-word data
//   req_addr                 byte address
//   req_wdata                store data, sub-word value in the low bits
//   resp_valid               one-cycle completion pulse
//   resp_rdata               load result (0 for stores and exceptions)
//   resp_exc                 memExc_t code
//   mem_req/mem_ack          memory request, held until single-cycle ack
//   mem_we                   1=write word, 0=read word
//   mem_addr                 word address
//   mem_wdata / mem_rdata    write / read word
// -----------------------------------------------------------------------------
package mem_access_unit_pkg;

    typedef enum logic [1:0] {
        MEM_WIDTH1 = 2'd0,
        MEM_WIDTH2 = 2'd1,
        MEM_WIDTH4 = 2'd2
    } memWidth_t;

    typedef enum logic [1:0] {
        EXC_NONE     = 2'd0,
        EXC_MISALIGN = 2'd1,
        EXC_RANGE    = 2'd2,
        EXC_TIMEOUT  = 2'd3
    } memExc_t;

endpackage

interface mem_access_unit_if #(
    parameter int unsigned ADDR_W = 12
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [1:0]        req_width;
    logic              req_sign_ext;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic [1:0]        resp_exc;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_ack;
    logic [31:0]       mem_rdata;

    modport master (
        input  req_valid, req_write, req_width, req_sign_ext, req_addr, req_wdata,
        input  mem_ack, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_exc,
        output mem_req, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output req_valid, req_write, req_width, req_sign_ext, req_addr, req_wdata,
        output mem_ack, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_exc,
        input  mem_req, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
//
// Initiator side of the data-memory interface. Accepts one load/store at a
// time from the pipeline MEM stage and drives a word-wide memory over a
// req/ack bus that has no byte enables. Sub-word loads are extracted from the
// read word and sign/zero-extended; sub-word stores are built by a
// read-modify-write. Misaligned, out-of-range and bus-timeout conditions are
// reported as exceptions.
//
// Ports
//   clk    clock, all state updates on posedge
//   reset  asynchronous, active-low reset
//   bus    mem_access_unit_if.master: pipeline request/response handshake and
//          memory req/ack bus (see mem_access_unit_if.sv)
//
// Parameters
//   ADDR_W      word-address width on the memory bus
//   ADDR_LIMIT  byte addresses >= this are out of range
//   TIMEOUT     cycles of mem_req without mem_ack before abort (>= 1)
// -----------------------------------------------------------------------------
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int unsigned ADDR_W     = 12,
    parameter logic [31:0] ADDR_LIMIT = 32'h3000,
    parameter int unsigned TIMEOUT    = 16
) (
    input  logic              clk,
    input  logic              reset,
    mem_access_unit_if.master bus
);

    localparam int unsigned TIMER_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        RD,
        WR,
        RESP
    } state_t;

    state_t state;
    state_t nextState;

    // Latched request
    logic [ADDR_W+1:0] addrReg;
    logic [1:0]        widthReg;
    logic              writeReg;
    logic              signExtReg;
    // Store data at accept; replaced by the merged word after the RMW read
    logic [31:0]       storeWord;

    logic [TIMER_W-1:0] timer;
    logic [31:0]        respRdataReg;
    memExc_t            respExcReg;

    // Incoming request decode
    logic reqIsByte;
    logic reqIsHalf;
    logic reqIsWord;
    logic reqMisaligned;
    logic reqOutOfRange;

    // Latched request decode
    logic latIsByte;
    logic latIsHalf;

    // Datapath
    logic [7:0]  laneByte;
    logic [15:0] laneHalf;
    logic [31:0] loadData;
    logic [31:0] mergedWord;
    logic        timerExpired;

    // FSM control
    logic        accept;
    logic        captureMerge;
    logic        timerClear;
    logic        timerInc;
    logic        finish;
    logic [31:0] finishData;
    memExc_t     finishExc;
    logic        reqReady;
    logic        memReq;
    logic        memWe;
    logic        respValid;

    always_comb begin
        reqIsByte     = (bus.req_width == MEM_WIDTH1);
        reqIsHalf     = (bus.req_width == MEM_WIDTH2);
        // The unused encoding is treated as a full word
        reqIsWord     = !reqIsByte && !reqIsHalf;
        reqMisaligned = (reqIsWord && (bus.req_addr[1:0] != 2'b00)) ||
                        (reqIsHalf && bus.req_addr[0]);
        reqOutOfRange = (bus.req_addr >= ADDR_LIMIT);
    end

    always_comb begin
        latIsByte    = (widthReg == MEM_WIDTH1);
        latIsHalf    = (widthReg == MEM_WIDTH2);
        timerExpired = (timer == TIMER_W'(TIMEOUT - 1));
    end

    // Little-endian lane extraction from the read word
    always_comb begin
        case (addrReg[1:0])
            2'd0:    laneByte = bus.mem_rdata[7:0];
            2'd1:    laneByte = bus.mem_rdata[15:8];
            2'd2:    laneByte = bus.mem_rdata[23:16];
            default: laneByte = bus.mem_rdata[31:24];
        endcase
        laneHalf = addrReg[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];

        if (latIsByte) begin
            loadData = {{24{signExtReg & laneByte[7]}}, laneByte};
        end else if (latIsHalf) begin
            loadData = {{16{signExtReg & laneHalf[15]}}, laneHalf};
        end else begin
            loadData = bus.mem_rdata;
        end
    end

    // Read-modify-write merge: only the addressed lane takes new data
    always_comb begin
        mergedWord = bus.mem_rdata;
        if (latIsByte) begin
            case (addrReg[1:0])
                2'd0:    mergedWord[7:0]   = storeWord[7:0];
                2'd1:    mergedWord[15:8]  = storeWord[7:0];
                2'd2:    mergedWord[23:16] = storeWord[7:0];
                default: mergedWord[31:24] = storeWord[7:0];
            endcase
        end else if (addrReg[1]) begin
            mergedWord[31:16] = storeWord[15:0];
        end else begin
            mergedWord[15:0] = storeWord[15:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState    = state;
        accept       = 1'b0;
        captureMerge = 1'b0;
        timerClear   = 1'b0;
        timerInc     = 1'b0;
        finish       = 1'b0;
        finishData   = '0;
        finishExc    = EXC_NONE;
        reqReady     = 1'b0;
        memReq       = 1'b0;
        memWe        = 1'b0;
        respValid    = 1'b0;

        case (state)
            IDLE: begin
                // Held low while reset is asserted so no request is offered
                reqReady = reset;
                if (bus.req_valid) begin
                    accept = 1'b1;
                    if (reqMisaligned) begin
                        nextState = RESP;
                        finish    = 1'b1;
                        finishExc = EXC_MISALIGN;
                    end else if (reqOutOfRange) begin
                        nextState = RESP;
                        finish    = 1'b1;
                        finishExc = EXC_RANGE;
                    end else if (bus.req_write && reqIsWord) begin
                        nextState  = WR;
                        timerClear = 1'b1;
                    end else begin
                        nextState  = RD;
                        timerClear = 1'b1;
                    end
                end
            end

            RD: begin
                memReq = 1'b1;
                if (bus.mem_ack) begin
                    if (writeReg) begin
                        nextState    = WR;
                        captureMerge = 1'b1;
                        timerClear   = 1'b1;
                    end else begin
                        nextState  = RESP;
                        finish     = 1'b1;
                        finishData = loadData;
                    end
                end else begin
                    timerInc = 1'b1;
                    if (timerExpired) begin
                        nextState = RESP;
                        finish    = 1'b1;
                        finishExc = EXC_TIMEOUT;
                    end
                end
            end

            WR: begin
                memReq = 1'b1;
                memWe  = 1'b1;
                if (bus.mem_ack) begin
                    nextState = RESP;
                    finish    = 1'b1;
                end else begin
                    timerInc = 1'b1;
                    if (timerExpired) begin
                        nextState = RESP;
                        finish    = 1'b1;
                        finishExc = EXC_TIMEOUT;
                    end
                end
            end

            RESP: begin
                respValid = 1'b1;
                nextState = IDLE;
            end

            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addrReg      <= '0;
            widthReg     <= '0;
            writeReg     <= 1'b0;
            signExtReg   <= 1'b0;
            storeWord    <= '0;
            timer        <= '0;
            respRdataReg <= '0;
            respExcReg   <= EXC_NONE;
        end else begin
            if (accept) begin
                addrReg    <= bus.req_addr[ADDR_W+1:0];
                widthReg   <= bus.req_width;
                writeReg   <= bus.req_write;
                signExtReg <= bus.req_sign_ext;
                storeWord  <= bus.req_wdata;
            end
            if (captureMerge) begin
                storeWord <= mergedWord;
            end

            if (timerClear) begin
                timer <= '0;
            end else if (timerInc) begin
                timer <= timer + 1'b1;
            end

            // Response fields live only for the RESP cycle and read 0 otherwise
            if (finish) begin
                respRdataReg <= finishData;
                respExcReg   <= finishExc;
            end else if (state == RESP) begin
                respRdataReg <= '0;
                respExcReg   <= EXC_NONE;
            end
        end
    end

    assign bus.req_ready  = reqReady;
    assign bus.mem_req    = memReq;
    assign bus.mem_we     = memWe;
    assign bus.mem_addr   = addrReg[ADDR_W+1:2];
    assign bus.mem_wdata  = storeWord;
    assign bus.resp_valid = respValid;
    assign bus.resp_rdata = respRdataReg;
    assign bus.resp_exc   = respExcReg;

endmodule

// File: tb/tb_mem_access_unit.sv
// -----------------------------------------------------------------------------
// tb_mem_access_unit
//
// Directed bench for mem_access_unit. Stimulus pushes the expected response
// (and the expected memory accesses) into queues; a response monitor and a
// memory model pop and compare independently of the stimulus.
// -----------------------------------------------------------------------------
module tb_mem_access_unit;
    import mem_access_unit_pkg::*;

    typedef struct {
        string       tag;
        logic [31:0] data;
        logic [1:0]  exc;
        int          lat;
        int          acceptCyc;
    } resp_t;

    typedef struct {
        string       tag;
        logic        we;
        logic [11:0] addr;
        logic [31:0] wdata;
    } acc_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    mem_access_unit_if #(.ADDR_W(12)) bus ();

    mem_access_unit #(
        .ADDR_W    (12),
        .ADDR_LIMIT(32'h3000),
        .TIMEOUT   (16)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int          nCompared   = 0;
    int          nMismatched = 0;
    int          cyc         = 0;
    logic [31:0] mem [0:4095];
    int unsigned ackDelay    = 0;
    bit          stall       = 1'b0;
    bit          strayAck    = 1'b0;
    resp_t       expQ[$];
    acc_t        accQ[$];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
        end
    endfunction

    // Memory model: acks after ackDelay wait cycles, checks each access
    initial begin : memModel
        int unsigned waitCnt;
        acc_t        a;
        waitCnt       = 0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(negedge clk);
            bus.mem_ack = 1'b0;
            if (strayAck) begin
                bus.mem_ack = 1'b1;
                strayAck    = 1'b0;
            end else if (!reset || !bus.mem_req || stall) begin
                waitCnt = 0;
            end else if (waitCnt < ackDelay) begin
                waitCnt++;
            end else begin
                waitCnt     = 0;
                bus.mem_ack = 1'b1;
                if (accQ.size() == 0) begin
                    nCompared++;
                    nMismatched++;
                    $display("FAIL unexpected access: got mem_req we=%0d addr=%0d, required none", bus.mem_we, bus.mem_addr);
                end else begin
                    a = accQ.pop_front();
                    check({a.tag, " mem_we"}, 32'(bus.mem_we), 32'(a.we));
                    check({a.tag, " mem_addr"}, 32'(bus.mem_addr), 32'(a.addr));
                    if (a.we) check({a.tag, " mem_wdata"}, bus.mem_wdata, a.wdata);
                end
                if (bus.mem_we) mem[bus.mem_addr] = bus.mem_wdata;
                else            bus.mem_rdata = mem[bus.mem_addr];
            end
        end
    end

    // Response monitor
    initial begin : respMonitor
        resp_t e;
        forever begin
            @(negedge clk);
            if (bus.resp_valid) begin
                if (expQ.size() == 0) begin
                    nCompared++;
                    nMismatched++;
                    $display("FAIL unexpected response: got resp_valid=1 exc=%0d, required no response", bus.resp_exc);
                end else begin
                    e = expQ.pop_front();
                    check({e.tag, " resp_rdata"}, bus.resp_rdata, e.data);
                    check({e.tag, " resp_exc"}, 32'(bus.resp_exc), 32'(e.exc));
                    check({e.tag, " latency"}, 32'(cyc - e.acceptCyc + 1), 32'(e.lat));
                end
            end else if (bus.resp_rdata != '0 || bus.resp_exc != '0) begin
                nCompared++;
                nMismatched++;
                $display("FAIL idle response fields: got rdata=0x%08h exc=%0d, required 0", bus.resp_rdata, bus.resp_exc);
            end
        end
    end

    task automatic drain();
        int unsigned guard;
        guard = 0;
        while ((expQ.size() != 0 || accQ.size() != 0) && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        if (expQ.size() != 0 || accQ.size() != 0) begin
            nCompared++;
            nMismatched++;
            $display("FAIL drain: got %0d responses / %0d accesses outstanding, required 0", expQ.size(), accQ.size());
            expQ.delete();
            accQ.delete();
        end
    endtask

    task automatic issue(input string tag, input logic wr, input logic [1:0] width, input logic sx,
                         input logic [31:0] addr, input logic [31:0] wdata, input bit expectResp,
                         input logic [31:0] expData, input logic [1:0] expExc, input int expLat);
        int unsigned guard;
        resp_t       e;
        guard = 0;
        @(negedge clk);
        while (!bus.req_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check({tag, " req_ready before accept"}, 32'(bus.req_ready), 32'd1);
        if (!bus.req_ready) return;
        bus.req_valid    = 1'b1;
        bus.req_write    = wr;
        bus.req_width    = width;
        bus.req_sign_ext = sx;
        bus.req_addr     = addr;
        bus.req_wdata    = wdata;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.req_addr  = 32'hFFFF_FFFF;
        bus.req_wdata = 32'h0BAD_0BAD;
        check({tag, " req_ready after accept"}, 32'(bus.req_ready), 32'd0);
        if (expectResp) begin
            e.tag       = tag;
            e.data      = expData;
            e.exc       = expExc;
            e.lat       = expLat;
            e.acceptCyc = cyc;
            expQ.push_back(e);
        end
    endtask

    task automatic doLoad(input string tag, input logic [1:0] width, input logic sx, input logic [31:0] addr,
                          input int unsigned delay, input logic [31:0] expData, input int expLat);
        acc_t a;
        drain();
        ackDelay = delay;
        a.tag    = tag;
        a.we     = 1'b0;
        a.addr   = addr[13:2];
        a.wdata  = '0;
        accQ.push_back(a);
        issue(tag, 1'b0, width, sx, addr, 32'h0, 1'b1, 32'h0 | expData, 2'd0, expLat);
    endtask

    task automatic doStore(input string tag, input logic [1:0] width, input logic [31:0] addr,
                           input logic [31:0] wdata, input int unsigned delay, input logic [31:0] expWord,
                           input int expLat);
        acc_t a;
        drain();
        ackDelay = delay;
        a.tag    = tag;
        a.addr   = addr[13:2];
        if (width != 2'd2) begin
            a.we    = 1'b0;
            a.wdata = '0;
            accQ.push_back(a);
        end
        a.we    = 1'b1;
        a.wdata = expWord;
        accQ.push_back(a);
        issue(tag, 1'b1, width, 1'b0, addr, wdata, 1'b1, 32'h0, 2'd0, expLat);
    endtask

    task automatic doExc(input string tag, input logic wr, input logic [1:0] width, input logic [31:0] addr,
                         input logic [1:0] expExc);
        drain();
        issue(tag, wr, width, 1'b1, addr, 32'hA5A5_A5A5, 1'b1, 32'h0, expExc, 1);
    endtask

    initial begin : watchdog
        #200000;
        nMismatched++;
        $display("FAIL watchdog: simulation did not complete within 200000 time units");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

    initial begin : stimulus
        int unsigned reqCycles;

        for (int unsigned i = 0; i < 4096; i++) mem[i] = '0;
        mem[64]   = 32'h8899_AABB;
        mem[65]   = 32'h8899_AABB;
        mem[3071] = 32'h7F00_0000;

        bus.req_valid    = 1'b0;
        bus.req_write    = 1'b0;
        bus.req_width    = 2'd0;
        bus.req_sign_ext = 1'b0;
        bus.req_addr     = '0;
        bus.req_wdata    = '0;

        // Reset state
        #1 reset = 1'b0;
        #20;
        check("reset req_ready", 32'(bus.req_ready), 32'd0);
        check("reset mem_req", 32'(bus.mem_req), 32'd0);
        check("reset mem_we", 32'(bus.mem_we), 32'd0);
        check("reset resp_valid", 32'(bus.resp_valid), 32'd0);
        check("reset resp_rdata", bus.resp_rdata, 32'h0);
        check("reset resp_exc", 32'(bus.resp_exc), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("post-reset req_ready", 32'(bus.req_ready), 32'd1);

        // Loads
        doLoad("word load 0x104 2-wait", 2'd2, 1'b0, 32'h0000_0104, 2, 32'h8899_AABB, 4);
        doLoad("byte load 0x103 sext", 2'd0, 1'b1, 32'h0000_0103, 0, 32'hFFFF_FF88, 2);
        doLoad("byte load 0x103 zext", 2'd0, 1'b0, 32'h0000_0103, 0, 32'h0000_0088, 2);
        doLoad("half load 0x106 sext", 2'd1, 1'b1, 32'h0000_0106, 1, 32'hFFFF_8899, 3);
        doLoad("half load 0x104 zext", 2'd1, 1'b0, 32'h0000_0104, 0, 32'h0000_AABB, 2);
        doLoad("byte load 0x105 sext", 2'd0, 1'b1, 32'h0000_0105, 0, 32'hFFFF_FFAA, 2);
        doLoad("byte load 0x2FFF sext", 2'd0, 1'b1, 32'h0000_2FFF, 0, 32'h0000_007F, 2);

        // Stores
        drain();
        mem[64] = 32'hDEAD_BEEF;
        doStore("half store 0x102", 2'd1, 32'h0000_0102, 32'hFFFF_1234, 1, 32'h1234_BEEF, 5);
        drain();
        mem[64] = 32'hDEAD_BEEF;
        doStore("byte store 0x101", 2'd0, 32'h0000_0101, 32'hAAAA_AA55, 0, 32'hDEAD_55EF, 3);
        doLoad("word load 0x100 after store", 2'd2, 1'b0, 32'h0000_0100, 0, 32'hDEAD_55EF, 2);
        doStore("word store 0x200", 2'd2, 32'h0000_0200, 32'hCAFE_F00D, 0, 32'hCAFE_F00D, 2);
        doLoad("word load 0x200", 2'd2, 1'b0, 32'h0000_0200, 0, 32'hCAFE_F00D, 2);

        // Exceptions
        doExc("word load 0x102 misaligned", 1'b0, 2'd2, 32'h0000_0102, 2'd1);
        doExc("byte load 0x3000 range", 1'b0, 2'd0, 32'h0000_3000, 2'd2);
        doExc("half load 0x101 misaligned", 1'b0, 2'd1, 32'h0000_0101, 2'd1);
        doExc("word store 0x3002 precedence", 1'b1, 2'd2, 32'h0000_3002, 2'd1);
        doExc("byte store 0xFFFFFFFF range", 1'b1, 2'd0, 32'hFFFF_FFFF, 2'd2);

        // Bus timeout
        drain();
        stall = 1'b1;
        issue("timeout load", 1'b0, 2'd2, 1'b0, 32'h0000_0104, 32'h0, 1'b1, 32'h0, 2'd3, 17);
        reqCycles = 0;
        @(negedge clk);
        while (bus.mem_req && reqCycles < 100) begin
            reqCycles++;
            @(negedge clk);
        end
        check("timeout mem_req cycles", reqCycles, 32'd16);
        drain();
        stall    = 1'b0;
        strayAck = 1'b1;
        repeat (3) @(negedge clk);
        check("stray ack mem_req", 32'(bus.mem_req), 32'd0);
        check("stray ack req_ready", 32'(bus.req_ready), 32'd1);
        doLoad("load after timeout", 2'd2, 1'b0, 32'h0000_0104, 0, 32'h8899_AABB, 2);

        // Reset while writing
        drain();
        stall = 1'b1;
        issue("store aborted by reset", 1'b1, 2'd2, 1'b0, 32'h0000_0300, 32'h1111_2222, 1'b0, 32'h0, 2'd0, 0);
        @(negedge clk);
        check("abort store in WR mem_we", 32'(bus.mem_we), 32'd1);
        check("abort store in WR mem_req", 32'(bus.mem_req), 32'd1);
        repeat (2) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("async reset mem_req", 32'(bus.mem_req), 32'd0);
        check("async reset req_ready", 32'(bus.req_ready), 32'd0);
        check("async reset resp_valid", 32'(bus.resp_valid), 32'd0);
        repeat (3) @(negedge clk);
        stall = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        check("after release req_ready", 32'(bus.req_ready), 32'd1);
        check("after release mem_req", 32'(bus.mem_req), 32'd0);
        doLoad("load after reset", 2'd2, 1'b0, 32'h0000_0104, 1, 32'h8899_AABB, 3);

        drain();
        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
